// File: rtl/instruction_decoder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_decoder_pipe: RV32/64 base-format decoder, 2-entry skid pipe   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module instruction_decoder_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] decode_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  // ---------------------------------------------------------------- decode
  logic [2:0]      dec_fmt_raw;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm_ext;
  entry_t          dec_entry;

  always_comb begin
    dec_fmt_raw = FMT_ILL;
    case (instruction[6:0])
      7'h33, 7'h3B:                      dec_fmt_raw = FMT_R;
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: dec_fmt_raw = FMT_I;
      7'h23:                             dec_fmt_raw = FMT_S;
      7'h63:                             dec_fmt_raw = FMT_B;
      7'h37, 7'h17:                      dec_fmt_raw = FMT_U;
      7'h6F:                             dec_fmt_raw = FMT_J;
      default:                           dec_fmt_raw = FMT_ILL;
    endcase
    dec_illegal = (dec_fmt_raw == FMT_ILL) || (instruction[1:0] != 2'b11);
    dec_fmt     = dec_illegal ? FMT_ILL : dec_fmt_raw;
  end

  // Immediate built on the final format, so illegal words fall to zero.
  always_comb begin
    dec_imm32 = 32'd0;
    case (dec_fmt)
      FMT_I: dec_imm32 = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S: dec_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B: dec_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: dec_imm32 = {instruction[31:12], 12'd0};
      FMT_J: dec_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
      default: dec_imm32 = 32'd0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_imm_wide
      assign dec_imm_ext = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
    end else begin : g_imm_narrow
      assign dec_imm_ext = dec_imm32[XLEN-1:0];
    end
  endgenerate

  always_comb begin
    dec_entry         = '0;
    dec_entry.opcode  = instruction[6:0];
    dec_entry.rd      = instruction[11:7];
    dec_entry.funct3  = instruction[14:12];
    dec_entry.rs1     = instruction[19:15];
    dec_entry.rs2     = instruction[24:20];
    dec_entry.funct7  = instruction[31:25];
    dec_entry.imm     = dec_imm_ext;
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = dec_illegal;
  end

  // ---------------------------------------------------------------- pipe
  occ_t             state_q,    state_d;
  logic             in_ready_q, in_ready_d;
  entry_t           out_q,      out_d;
  entry_t           skid_q,     skid_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             accept;
  logic             deliver;

  assign accept  = in_valid && in_ready_q && (state_q != ST_FULL);
  assign deliver = (state_q != ST_EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    count_d = count_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = dec_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          out_d = dec_entry;
        end else if (accept) begin
          skid_d  = dec_entry;
          state_d = ST_FULL;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (deliver) begin
      count_d = count_q + CNT_W'(1);
    end
    // Registered ready: reflects whether the skid slot is free next cycle.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      count_q    <= count_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != ST_EMPTY);
  assign opcode       = out_q.opcode;
  assign rd           = out_q.rd;
  assign funct3       = out_q.funct3;
  assign rs1          = out_q.rs1;
  assign rs2          = out_q.rs2;
  assign funct7       = out_q.funct7;
  assign imm          = out_q.imm;
  assign fmt          = out_q.fmt;
  assign illegal      = out_q.illegal;
  assign decode_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decoder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instruction_decoder_pipe: directed vector bench for the decoder pipe    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_instruction_decoder_pipe;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [6:0]       funct7;
  logic [XLEN-1:0]  imm;
  logic [2:0]       fmt;
  logic             illegal;
  logic [CNT_W-1:0] decode_count;

  instruction_decoder_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .fmt(fmt), .illegal(illegal),
    .decode_count(decode_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] exp_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] mk_addi(input logic [4:0] rdn, input logic [11:0] im);
    return {im, 5'd0, 3'd0, rdn, 7'h13};
  endfunction

  function automatic logic [127:0] pack_dut();
    return {28'd0, opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal};
  endfunction

  function automatic logic [127:0] pack_vec(input vec_t v);
    return {28'd0, v.opc, v.rd, v.f3, v.rs1, v.rs2, v.f7, v.imm, v.fmt, v.ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back addi stream with out_ready held high; tag = rd = imm.
  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      instruction = mk_addi(5'(base + i), 12'(base + i));
      tick();
      if (i > 0) exp_cnt = exp_cnt + 1'b1;
      chk($sformatf("stream_ready_%0d", base + i), 128'(in_ready), 128'(1));
      chk($sformatf("stream_valid_%0d", base + i), 128'(out_valid), 128'(1));
      chk($sformatf("stream_rd_%0d", base + i), 128'(rd), 128'(base + i));
      chk($sformatf("stream_imm_%0d", base + i), 128'(imm), 128'(base + i));
      chk($sformatf("stream_cnt_%0d", base + i), 128'(decode_count), 128'(exp_cnt));
    end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("stream_drain_valid", 128'(out_valid), 128'(0));
    chk("stream_drain_cnt", 128'(decode_count), 128'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //           instr         opc    rd  f3 rs1 rs2 f7     imm                     fmt ill
    vecs[0]  = '{32'h123ABCDF, 7'h5F, 25, 3, 21,  3, 7'h09, 64'h0,                  7, 1};
    vecs[1]  = '{32'hFFF00093, 7'h13,  1, 0,  0, 31, 7'h7F, 64'hFFFFFFFFFFFFFFFF,   1, 0};
    vecs[2]  = '{32'h00112223, 7'h23,  4, 2,  2,  1, 7'h00, 64'h4,                  2, 0};
    vecs[3]  = '{32'h80000037, 7'h37,  0, 0,  0,  0, 7'h40, 64'hFFFFFFFF80000000,   4, 0};
    vecs[4]  = '{32'h002081B3, 7'h33,  3, 0,  1,  2, 7'h00, 64'h0,                  0, 0};
    vecs[5]  = '{32'h00208463, 7'h63,  8, 0,  1,  2, 7'h00, 64'h8,                  3, 0};
    vecs[6]  = '{32'h001000EF, 7'h6F,  1, 0,  0,  1, 7'h00, 64'h800,                5, 0};
    vecs[7]  = '{32'hFFFFF06F, 7'h6F,  0, 7, 31, 31, 7'h7F, 64'hFFFFFFFFFFFFFFFE,   5, 0};
    vecs[8]  = '{32'h00000000, 7'h00,  0, 0,  0,  0, 7'h00, 64'h0,                  7, 1};
    vecs[9]  = '{32'hFE112E23, 7'h23, 28, 2,  2,  1, 7'h7F, 64'hFFFFFFFFFFFFFFFC,   2, 0};
    vecs[10] = '{32'h12345037, 7'h37,  0, 5,  8,  3, 7'h09, 64'h12345000,           4, 0};
    vecs[11] = '{32'h000080E7, 7'h67,  1, 0,  1,  0, 7'h00, 64'h0,                  1, 0};

    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    instruction = 32'd0;
    exp_cnt     = '0;
    #3;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_count", 128'(decode_count), 128'(0));
    chk("rst_fields", pack_dut(), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_release_ready", 128'(in_ready), 128'(1));

    // Single-word decode of every table entry, one cycle after accept.
    for (int v = 0; v < NVEC; v++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      instruction = vecs[v].instr;
      chk($sformatf("vec%0d_ready", v), 128'(in_ready), 128'(1));
      tick();
      chk($sformatf("vec%0d_valid", v), 128'(out_valid), 128'(1));
      chk($sformatf("vec%0d_fields", v), pack_dut(), pack_vec(vecs[v]));
      chk($sformatf("vec%0d_cnt", v), 128'(decode_count), 128'(exp_cnt));
      @(negedge clk);
      in_valid = 1'b0;
      tick();
      exp_cnt = exp_cnt + 1'b1;
      chk($sformatf("vec%0d_drain", v), 128'(out_valid), 128'(0));
    end

    // Backpressure: three words offered with the consumer stalled.
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset   = 1'b0;
    exp_cnt = '0;
    tick();
    @(negedge clk);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = mk_addi(5'd5, 12'd5);
    tick();
    chk("bp_a_valid", 128'(out_valid), 128'(1));
    chk("bp_a_rd", 128'(rd), 128'(5));
    @(negedge clk);
    instruction = mk_addi(5'd6, 12'd6);
    tick();
    chk("bp_full_ready", 128'(in_ready), 128'(0));
    chk("bp_full_rd", 128'(rd), 128'(5));
    @(negedge clk);
    instruction = mk_addi(5'd7, 12'd7);
    repeat (2) tick();
    chk("bp_hold_ready", 128'(in_ready), 128'(0));
    chk("bp_hold_rd", 128'(rd), 128'(5));
    chk("bp_hold_imm", 128'(imm), 128'(5));
    chk("bp_hold_cnt", 128'(decode_count), 128'(0));
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    chk("bp_b_rd", 128'(rd), 128'(6));
    chk("bp_b_cnt", 128'(decode_count), 128'(1));
    chk("bp_b_ready", 128'(in_ready), 128'(1));
    tick();
    chk("bp_c_rd", 128'(rd), 128'(7));
    chk("bp_c_cnt", 128'(decode_count), 128'(2));
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("bp_done_valid", 128'(out_valid), 128'(0));
    chk("bp_done_cnt", 128'(decode_count), 128'(3));
    exp_cnt = 4'd3;

    // Continuous traffic, then wrap the 4-bit counter from 15 to 0.
    stream(10, 1);
    stream(3, 20);
    chk("cnt_wrapped", 128'(decode_count), 128'(0));

    // Reset while FULL: entries discarded immediately and never delivered.
    @(negedge clk);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = mk_addi(5'd9, 12'd9);
    tick();
    @(negedge clk);
    instruction = mk_addi(5'd10, 12'd10);
    tick();
    chk("mid_full_ready", 128'(in_ready), 128'(0));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_cnt", 128'(decode_count), 128'(0));
    chk("mid_rst_fields", pack_dut(), 128'(0));
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mid_after_valid_%0d", k), 128'(out_valid), 128'(0));
      chk($sformatf("mid_after_cnt_%0d", k), 128'(decode_count), 128'(0));
    end
    chk("mid_after_ready", 128'(in_ready), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
